tdm_mult_scheduler: RTL and testbench
=====================================

Name: tdm_mult_scheduler

Overview:
Shares one pipelined DSP multiplier between NUM_REQ requesters, each with a valid/ready operand interface.
- Picks one requester per clock, using either strict TDM slots or work-conserving round-robin.
- Registers the winner's operands into the multiplier and tags each issue with the requester id.
- Returns each product with its id after the fixed multiplier latency.
- Sits between the per-channel input sources and the shared mult instance, replacing a free-running round-robin mux.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH_A, 8, operand A width.
- WIDTH_B, 8, operand B width.
- MULT_LAT, 3, cycles from mult_a/mult_b register output to valid mult_p (1..6).
- ID_W, $clog2(NUM_REQ) (min 1), requester id width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- mode  in  1  0 = strict TDM, 1 = work-conserving round-robin.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ x WIDTH_A  per-requester operand A.
- req_b  in  NUM_REQ x WIDTH_B  per-requester operand B.
- mult_a  out  WIDTH_A  registered operand A to the multiplier.
- mult_b  out  WIDTH_B  registered operand B to the multiplier.
- mult_p  in  WIDTH_A+WIDTH_B  multiplier product.
- rsp_valid  out  1  product valid.
- rsp_id  out  ID_W  requester that owns the product.
- rsp_data  out  WIDTH_A+WIDTH_B  product (mult_p passed through).
- idle_cnt  out  16  saturating count of strict-TDM slots lost because the slot owner was not valid.

Behaviour:
- Reset (rst=0, asynchronous): ptr=0, mult_a=0, mult_b=0, tag pipe cleared, rsp_valid=0, rsp_id=0, idle_cnt=0.
  - req_ready=0 while in reset.
  - In-flight products are discarded; no rsp_valid for issues made before reset.
- Handshake: a transfer occurs on a clock edge where req_valid[i] & req_ready[i].
  - req_ready is combinational from req_valid, ptr and mode.
  - At most one bit of req_ready is high per cycle.
  - Requesters hold req_a/req_b stable while valid and not ready.
- Strict TDM (mode=0):
  - The slot owner is ptr; req_ready[ptr]=req_valid[ptr].
  - ptr advances by 1 every cycle, wrapping from NUM_REQ-1 to 0, whether or not a grant occurs.
  - If req_valid[ptr]=0, idle_cnt increments, saturating at 16'hFFFF.
- Work-conserving (mode=1):
  - Grant the first valid requester scanning ptr, ptr+1, ... (mod NUM_REQ).
  - On a grant to g, ptr <= (g+1) mod NUM_REQ.
  - With no valid requester, ptr holds and idle_cnt holds.
- Mode change takes effect on the cycle the new value is sampled; ptr is not reset.
- Issue stage: on a grant, mult_a/mult_b <= winner's req_a/req_b and the tag {1, id} enters the tag pipe. With no grant, mult_a/mult_b <= 0 and tag valid <= 0.
- Tag pipe:
  - Shift register of MULT_LAT stages; its head is loaded with the issue stage.
  - rsp_valid/rsp_id come from the tail stage.
  - rsp_data = mult_p, combinational.
- Latency: a handshake at edge T produces rsp_valid during the cycle after edge T+1+MULT_LAT-1, i.e. 1+MULT_LAT cycles after acceptance.
- Throughput: 1 issue per cycle. Responses keep issue order and have no backpressure; the consumer must always accept.
- Widths: product is unsigned, full width WIDTH_A+WIDTH_B, never truncated.

Decomposition:
- Package tdm_pkg: mode_e {MODE_TDM=1'b0, MODE_WC=1'b1}, IDLE_CNT_W=16, a tag struct {logic vld; logic [ID_W-1:0] id} parameterised through a localparam max ID width of 3.
- One sub-module, rr_arbiter:
  - Combinational rotate-priority pick over req_valid starting at ptr.
  - Outputs grant one-hot, grant id and any_grant.
  - The scheduler owns the ptr register and the mode selection.

Test Plan:
- Reset mid-stream: issue 3 products, assert rst low one cycle -> all outputs 0, no rsp_valid for those 3 in the following 1+MULT_LAT cycles.
- Strict TDM, both valid, din0 a=5 b=7, din1 a=3 b=9 (MULT_LAT=3) -> rsp alternates id0=35, id1=27, first rsp 4 cycles after first accept, idle_cnt=0.
- Strict TDM, only req 1 valid -> req_ready[1] every 2nd cycle, idle_cnt +1 every 2nd cycle; force idle_cnt near 16'hFFFE and check it saturates at 16'hFFFF.
- Work-conserving, only req 1 valid, a=255 b=255 -> accepted every cycle, rsp_data=16'hFE01 every cycle with id=1, idle_cnt unchanged.
- Work-conserving, NUM_REQ=4, all valid -> grants 0,1,2,3,0 in order. Drop req 2 -> sequence 0,1,3,0.
- Switch mode 1->0 while ptr=3 -> next slot owner is 3, then 0; no duplicate or lost transfers (scoreboard counts match).

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types for the TDM multiplier scheduler: mode encoding, counter width
// and the id tag that travels alongside each issued multiply.
package tdm_pkg;

  typedef enum logic {
    MODE_TDM = 1'b0,
    MODE_WC  = 1'b1
  } mode_e;

  localparam int IDLE_CNT_W   = 16;
  localparam int TAG_ID_MAX_W = 3;

  typedef struct packed {
    logic                    vld;
    logic [TAG_ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority pick: first asserted req_valid found scanning from ptr upward,
// wrapping modulo NUM_REQ. Purely combinational; the caller owns ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!any_grant && req_valid[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule

// File: rtl/tdm_mult_scheduler.sv
// Shares one pipelined multiplier among NUM_REQ requesters using strict TDM slots
// or work-conserving round-robin, returning each product tagged with its owner id.
module tdm_mult_scheduler
  import tdm_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int WIDTH_A  = 8,
  parameter int WIDTH_B  = 8,
  parameter int MULT_LAT = 3,
  parameter int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              mode,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][WIDTH_A-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH_B-1:0]   req_b,
  output logic [WIDTH_A-1:0]                mult_a,
  output logic [WIDTH_B-1:0]                mult_b,
  input  logic [WIDTH_A+WIDTH_B-1:0]        mult_p,
  output logic                              rsp_valid,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [WIDTH_A+WIDTH_B-1:0]        rsp_data,
  output logic [IDLE_CNT_W-1:0]             idle_cnt
);

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
    return (p == ID_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [IDLE_CNT_W-1:0] sat_inc(input logic [IDLE_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       ptr_nxt;
  logic [NUM_REQ-1:0]    wc_grant;
  logic [ID_W-1:0]       wc_id;
  logic                  wc_any;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  any_grant;
  logic                  slot_lost;
  logic [WIDTH_A-1:0]    mult_a_p0;
  logic [WIDTH_B-1:0]    mult_b_p0;
  logic [IDLE_CNT_W-1:0] idle_cnt_q;
  tag_t                  tag_p [MULT_LAT+1];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (wc_grant),
    .grant_id  (wc_id),
    .any_grant (wc_any)
  );

  // In TDM the slot always moves on; in WC ptr only moves past a winner.
  always_comb begin
    grant     = '0;
    grant_id  = ptr;
    any_grant = 1'b0;
    ptr_nxt   = ptr;
    slot_lost = 1'b0;
    if (mode_e'(mode) == MODE_TDM) begin
      grant[ptr] = req_valid[ptr];
      any_grant  = req_valid[ptr];
      slot_lost  = !req_valid[ptr];
      ptr_nxt    = wrap_inc(ptr);
    end else begin
      grant     = wc_grant;
      grant_id  = wc_id;
      any_grant = wc_any;
      if (wc_any) ptr_nxt = wrap_inc(wc_id);
    end
  end

  assign req_ready = rst ? grant : '0;

  // Stage p0: issue register feeding the multiplier; tag_p[1..MULT_LAT] track its latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      mult_a_p0  <= '0;
      mult_b_p0  <= '0;
      idle_cnt_q <= '0;
      for (int s = 0; s <= MULT_LAT; s++) tag_p[s] <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (slot_lost) idle_cnt_q <= sat_inc(idle_cnt_q);
      if (any_grant) begin
        mult_a_p0 <= req_a[grant_id];
        mult_b_p0 <= req_b[grant_id];
        tag_p[0]  <= '{vld: 1'b1, id: TAG_ID_MAX_W'(grant_id)};
      end else begin
        mult_a_p0 <= '0;
        mult_b_p0 <= '0;
        tag_p[0]  <= '0;
      end
      for (int s = 1; s <= MULT_LAT; s++) tag_p[s] <= tag_p[s-1];
    end
  end

  assign mult_a    = mult_a_p0;
  assign mult_b    = mult_b_p0;
  assign rsp_valid = tag_p[MULT_LAT].vld;
  assign rsp_id    = ID_W'(tag_p[MULT_LAT].id);
  assign rsp_data  = mult_p;
  assign idle_cnt  = idle_cnt_q;

endmodule

// File: tb/tb_tdm_mult_scheduler.sv
// Scoreboard bench for tdm_mult_scheduler: directed handshake vectors push expected
// products; an independent monitor pops and checks id, data and arrival cycle.
module tb_tdm_mult_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WA      = 8;
  localparam int WB      = 8;
  localparam int PW      = WA + WB;
  localparam int LAT     = 3;
  localparam int IDW     = 2;

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic                         mode = 1'b0;
  logic [NUM_REQ-1:0]           req_valid = '0;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ-1:0][WA-1:0]   req_a = '0;
  logic [NUM_REQ-1:0][WB-1:0]   req_b = '0;
  logic [WA-1:0]                mult_a;
  logic [WB-1:0]                mult_b;
  logic [PW-1:0]                mult_p;
  logic                         rsp_valid;
  logic [IDW-1:0]               rsp_id;
  logic [PW-1:0]                rsp_data;
  logic [15:0]                  idle_cnt;

  tdm_mult_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .WIDTH_A  (WA),
    .WIDTH_B  (WB),
    .MULT_LAT (LAT),
    .ID_W     (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_p    (mult_p),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .idle_cnt  (idle_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier with LAT register stages after mult_a/mult_b.
  logic [PW-1:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= PW'(mult_a) * PW'(mult_b);
    for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mult_p = mpipe[LAT-1];

  typedef struct {
    int            id;
    logic [PW-1:0] p;
    int            cyc;
  } exp_t;

  exp_t          sb_q [$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            stray  = 0;
  int            n_push = 0;
  int            n_pop  = 0;
  int            cyc    = 0;
  int            stray_before;
  logic [PW-1:0] exp_p [NUM_REQ];

  logic [3:0] d2_exp [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  logic [3:0] f_exp  [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every presented response must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        stray++;
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d data=0x%0h with empty scoreboard (cycle %0d)",
                 rsp_id, rsp_data, cyc);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.p));
        chk("rsp_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic set_req(input int i, input logic [WA-1:0] a, input logic [WB-1:0] b,
                         input logic [PW-1:0] p);
    req_a[i] = a;
    req_b[i] = b;
    exp_p[i] = p;
  endtask

  task automatic step(input string name, input logic [NUM_REQ-1:0] exp_rdy);
    @(negedge clk);
    chk(name, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb_q.push_back('{id: i, p: exp_p[i], cyc: cyc + 1 + LAT});
        n_push++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state with every requester asking.
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_mult_a", 32'(mult_a), 32'd0);
    chk("rst_mult_b", 32'(mult_b), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_idle_cnt", 32'(idle_cnt), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Strict TDM, all valid.
    set_req(0, 8'd5, 8'd7, 16'd35);
    set_req(1, 8'd3, 8'd9, 16'd27);
    set_req(2, 8'd2, 8'd4, 16'd8);
    set_req(3, 8'd10, 8'd11, 16'd110);
    mode = 1'b0;
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) step("tdm_all_ready", 4'(1 << (k % 4)));
    chk("tdm_all_idle", 32'(idle_cnt), 32'd0);

    // Strict TDM, only requester 1 valid.
    set_req(1, 8'd6, 8'd7, 16'd42);
    req_valid = 4'b0010;
    for (int k = 0; k < 8; k++) step("tdm_r1_ready", (k % 4 == 1) ? 4'b0010 : 4'b0000);
    chk("tdm_r1_idle", 32'(idle_cnt), 32'd6);

    // Work-conserving, all valid then requester 2 dropped.
    mode = 1'b1;
    set_req(1, 8'd3, 8'd9, 16'd27);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) step("wc_all_ready", 4'(1 << (k % 4)));
    req_valid = 4'b1011;
    for (int k = 0; k < 6; k++) step("wc_drop2_ready", d2_exp[k]);
    chk("wc_idle_hold", 32'(idle_cnt), 32'd6);

    // Work-conserving, only requester 1 at full-scale operands.
    set_req(1, 8'd255, 8'd255, 16'hFE01);
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) step("wc_r1_ready", 4'b0010);
    chk("wc_r1_idle", 32'(idle_cnt), 32'd6);

    // Move ptr to 3, then switch to strict TDM.
    set_req(1, 8'd3, 8'd9, 16'd27);
    req_valid = 4'hF;
    step("wc_to_ptr3", 4'b0100);
    mode = 1'b0;
    for (int k = 0; k < 5; k++) step("mode_switch_ready", f_exp[k]);
    chk("mode_switch_idle", 32'(idle_cnt), 32'd6);

    // Drain in WC mode with nothing valid.
    mode = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 6; k++) step("drain_ready", 4'b0000);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("drain_rsp_count", 32'(n_pop), 32'(n_push));

    // Reset mid-stream: three issues in flight are discarded.
    set_req(0, 8'd1, 8'd2, 16'd2);
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) step("prerst_ready", 4'b0001);
    #1 rst = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_mult_a", 32'(mult_a), 32'd0);
    chk("midrst_mult_b", 32'(mult_b), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_idle_cnt", 32'(idle_cnt), 32'd0);
    n_push -= sb_q.size();
    sb_q.delete();
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    stray_before = stray;
    for (int k = 0; k < 1 + LAT + 2; k++) step("postrst_ready", 4'b0000);
    chk("postrst_no_rsp", 32'(stray), 32'(stray_before));

    // ptr restarted at 0: requester 3 owns the fourth slot.
    mode = 1'b0;
    set_req(3, 8'd12, 8'd12, 16'd144);
    req_valid = 4'b1000;
    for (int k = 0; k < 4; k++) step("postrst_ptr", (k == 3) ? 4'b1000 : 4'b0000);
    chk("postrst_idle", 32'(idle_cnt), 32'd3);

    // idle_cnt saturation.
    req_valid = '0;
    force dut.idle_cnt_q = 16'hFFFD;
    #1;
    release dut.idle_cnt_q;
    step("sat_ready", 4'b0000);
    chk("idle_pre_sat", 32'(idle_cnt), 32'hFFFE);
    for (int k = 0; k < 3; k++) step("sat_ready", 4'b0000);
    chk("idle_saturated", 32'(idle_cnt), 32'hFFFF);

    for (int k = 0; k < 2; k++) step("final_ready", 4'b0000);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("final_rsp_count", 32'(n_pop), 32'(n_push));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
